// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-mode encoding and the
// parity helper, which is also used by uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_LOW,
    PAR_HIGH
  } parity_mode_t;

  // Maps the single-character PARITY parameter ("N","E","O","L","H") to a mode.
  function automatic parity_mode_t parity_mode(input logic [7:0] c);
    case (c)
      "N":     return PAR_NONE;
      "E":     return PAR_EVEN;
      "O":     return PAR_ODD;
      "H":     return PAR_HIGH;
      default: return PAR_LOW;
    endcase
  endfunction

  // Data is zero-extended to 9 bits; the unused upper bits leave the XOR unchanged.
  function automatic logic expected_parity(input logic [8:0] data, input parity_mode_t mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      PAR_HIGH: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, bit-period counter and mid-bit sampler for uart_rx.
// UART_RX_MAJORITY_EN selects a 2-of-3 majority vote around mid-bit.
module uart_rx_sampler #(
  parameter int unsigned DIV  = 86,
  parameter int unsigned HALF = 43
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_rx,
  input  logic i_restart,
  output logic o_rxs,
  output logic o_fall,
  output logic o_sample,
  output logic o_bit
);

  localparam int unsigned CW = $clog2(DIV + 1);

  logic          r_meta;
  logic          r_rxs;
  logic          r_prev;
  logic [CW-1:0] r_bcnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
      r_prev <= 1'b1;
      r_bcnt <= '0;
    end else begin
      r_meta <= i_rx;
      r_rxs  <= r_meta;
      r_prev <= r_rxs;
      if (i_restart || r_bcnt == CW'(DIV - 1))
        r_bcnt <= '0;
      else
        r_bcnt <= r_bcnt + 1'b1;
    end
  end

  assign o_rxs  = r_rxs;
  assign o_fall = r_prev & ~r_rxs;

`ifdef UART_RX_MAJORITY_EN
  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_bcnt == CW'(HALF - 2)) r_s0 <= r_rxs;
      if (r_bcnt == CW'(HALF - 1)) r_s1 <= r_rxs;
    end
  end

  // Third vote is the live value at HALF, so the strobe moves one cycle later.
  assign o_sample = (r_bcnt == CW'(HALF));
  assign o_bit    = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
`else
  assign o_sample = (r_bcnt == CW'(HALF - 1));
  assign o_bit    = r_rxs;
`endif

endmodule

// File: rtl/uart_rx.sv
// Multi-word UART receiver: collects WORD_COUNT characters into one bus with a
// one-cycle valid strobe. UART_RX_MAJORITY_EN enables majority bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 10000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned WORD_LEN   = 8,
  parameter int unsigned WORD_COUNT = 8,
  parameter logic [7:0]  PARITY     = "L",
  parameter int unsigned STOP       = 1,
  parameter int unsigned GAP_BITS   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rx_i,
  output logic [WORD_LEN*WORD_COUNT-1:0] rx_data_o,
  output logic                           rx_valid_o,
  output logic                           rx_parity_err_o,
  output logic                           rx_frame_err_o,
  output logic                           rx_timeout_o,
  output logic                           rx_busy_o
);

  localparam int unsigned  DIV     = CLK_RATE / BAUD_RATE;
  localparam int unsigned  HALF    = DIV / 2;
  localparam int unsigned  FW      = WORD_LEN * WORD_COUNT;
  localparam int unsigned  IDX_W   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned  GAP_LIM = GAP_BITS * DIV;
  localparam parity_mode_t PMODE   = parity_mode(PARITY);

  rx_state_t           r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [3:0]          r_bit;
  logic                r_stop;
  logic [31:0]         r_gap;
  logic                r_perr;
  logic [WORD_LEN-1:0] r_word;
  logic [FW-1:0]       r_frame;
  logic [FW-1:0]       r_data;
  logic                r_valid;
  logic                r_perr_out;
  logic                r_ferr;
  logic                r_tout;
  logic                r_busy;

  logic                w_rxs;
  logic                w_fall;
  logic                w_sample;
  logic                w_bit;
  logic                w_restart;
  logic [8:0]          w_word9;
  logic [FW-1:0]       w_frame;

  assign w_restart = (r_state == ST_IDLE || r_state == ST_GAP) && w_fall;

  uart_rx_sampler #(
    .DIV  (DIV),
    .HALF (HALF)
  ) u_sampler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_rx      (rx_i),
    .i_restart (w_restart),
    .o_rxs     (w_rxs),
    .o_fall    (w_fall),
    .o_sample  (w_sample),
    .o_bit     (w_bit)
  );

  assign w_word9 = 9'(r_word);

  // Frame image with the word in flight merged into its slot.
  always_comb begin
    w_frame = r_frame;
    for (int unsigned k = 0; k < WORD_COUNT; k++)
      if (r_idx == IDX_W'(k)) w_frame[k*WORD_LEN +: WORD_LEN] = r_word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_bit      <= '0;
      r_stop     <= 1'b0;
      r_gap      <= '0;
      r_perr     <= 1'b0;
      r_word     <= '0;
      r_frame    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr     <= 1'b0;
      r_tout     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr     <= 1'b0;
      r_tout     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_sample) begin
            if (w_bit) begin
              r_state <= (r_idx == '0) ? ST_IDLE : ST_GAP;
              if (r_idx == '0) r_busy <= 1'b0;
            end else begin
              r_state <= ST_DATA;
              r_bit   <= '0;
            end
          end
        end
        ST_DATA: begin
          if (w_sample) begin
            r_word <= {w_bit, r_word[WORD_LEN-1:1]};
            if (r_bit == 4'(WORD_LEN - 1)) begin
              r_state <= (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
              r_stop  <= 1'b0;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_sample) begin
            if (w_bit != expected_parity(w_word9, PMODE)) r_perr <= 1'b1;
            r_state <= ST_STOP;
            r_stop  <= 1'b0;
          end
        end
        ST_STOP: begin
          if (w_sample) begin
            if (!w_bit) begin
              r_ferr  <= 1'b1;
              r_state <= ST_BREAK;
              r_busy  <= 1'b0;
              r_idx   <= '0;
              r_perr  <= 1'b0;
            end else if (r_stop == 1'(STOP - 1)) begin
              if (r_idx == IDX_W'(WORD_COUNT - 1)) begin
                r_state    <= ST_DONE;
                r_data     <= w_frame;
                r_valid    <= 1'b1;
                r_perr_out <= r_perr;
                r_busy     <= 1'b0;
              end else begin
                r_frame <= w_frame;
                r_idx   <= r_idx + 1'b1;
                r_gap   <= '0;
                r_state <= ST_GAP;
              end
            end else begin
              r_stop <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (w_fall) begin
            r_state <= ST_START;
          end else if (r_gap == 32'(GAP_LIM - 1)) begin
            r_tout  <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_perr  <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_perr  <= 1'b0;
        end
        ST_BREAK: begin
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_data_o       = r_data;
  assign rx_valid_o      = r_valid;
  assign rx_parity_err_o = r_perr_out;
  assign rx_frame_err_o  = r_ferr;
  assign rx_timeout_o    = r_tout;
  assign rx_busy_o       = r_busy;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Multi-word UART receiver; the counterpart of the project's uart_tx.
- Deserialises WORD_COUNT back-to-back characters into one WORD_LEN*WORD_COUNT bus and presents it with a one-cycle valid strobe.
- Used on the host-facing bench/loopback side to capture oscillator sample frames.
- Also used for a future command channel into top.

Parameters:
- CLK_RATE, 10000000: clk_i frequency in Hz.
- BAUD_RATE, 115200: line rate. DIV = CLK_RATE/BAUD_RATE (integer truncation); HALF = DIV/2.
- WORD_LEN, 8: data bits per character, 5..9.
- WORD_COUNT, 8: characters per frame, >=1.
- PARITY, "L": "N" none, "E" even, "O" odd, "L" constant 0, "H" constant 1.
- STOP, 1: stop bits checked, 1 or 2.
- GAP_BITS, 16: max idle bit-times between characters of one frame before abort.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- rx_i  in  1  serial line, idle high, asynchronous to clk_i
- rx_data_o  out  WORD_LEN*WORD_COUNT  frame; word k at bits [k*WORD_LEN +: WORD_LEN], word 0 = first received
- rx_valid_o  out  1  one-cycle strobe, rx_data_o valid
- rx_parity_err_o  out  1  qualifies rx_valid_o: at least one word had bad parity
- rx_frame_err_o  out  1  one-cycle pulse: stop bit sampled low, frame aborted
- rx_timeout_o  out  1  one-cycle pulse: inter-word gap exceeded, frame aborted
- rx_busy_o  out  1  high from start-bit detect of word 0 until frame end or abort

Behaviour:
- Reset: all outputs 0, rx_data_o = 0, state IDLE, word index 0, synchroniser flops = 1.
- rx_i passes through a 2-FF synchroniser; all logic uses the synchronised value rxs.
- Bit-timing counter bcnt counts 0..DIV-1.
- Samples are taken at bcnt == HALF-1 of each bit period (mid-bit).
- IDLE: on rxs falling edge -> START, bcnt=0, rx_busy_o=1 (word 0 only).
- START: at mid-bit, rxs=1 is a false start -> IDLE/GAP, no error. rxs=0 -> DATA.
- DATA: WORD_LEN bits, LSB first, one per DIV cycles. Shift into word slot [idx].
- After DATA -> PARITY if PARITY != "N", else -> STOP.
- PARITY: compare the sample against the expected value (even/odd of data, or constant 0/1). A mismatch sets sticky perr; the frame continues.
- STOP: STOP samples. Any 0 -> frame_err pulse, frame discarded, -> BREAK.
- After the last stop: if idx == WORD_COUNT-1 -> DONE, else idx++ -> GAP.
- GAP: waits for a falling edge -> START. Counts idle clocks; at GAP_BITS*DIV -> rx_timeout_o pulse, discard, -> IDLE.
- DONE (1 cycle): rx_data_o updates, rx_valid_o=1, rx_parity_err_o=perr. Clear perr and idx, busy=0, -> IDLE.
- BREAK: stays until rxs = 1, then -> IDLE. Busy deasserts on entry.
- rx_data_o holds its value until the next DONE. An aborted frame never alters rx_data_o.
- Latency: rx_valid_o asserts 1 cycle after the mid-sample of the last stop bit, plus 2 synchroniser cycles from the line.
- rst_i mid-frame: immediate return to reset state, no pulses.
- rx_i held low while idle: START then frame_err at the first stop; BREAK until release. No repeated errors.
- Simultaneous events: only one of valid/frame_err/timeout pulses per cycle, by construction of the FSM.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rxs at bcnt = HALF-2, HALF-1, HALF. False-start and stop checks also use the majority.
- Undefined: single sample at HALF-1; the extra sample registers are not built.

Decomposition:
- Package uart_pkg holds the shared state enum (IDLE, START, DATA, PARITY, STOP, GAP, DONE, BREAK) and a parity-mode encoding.
- It also holds a function expected_parity(data, mode), shared with uart_tx.
- One sub-module, uart_rx_sampler, containing the synchroniser, bcnt and the mid-bit (majority) sampler. It outputs a sample strobe plus bit value.
- The frame FSM and shift registers stay in uart_rx.

Test Plan:
- Defaults (DIV=86), PARITY "L", send 8 bytes 0x01..0x08 -> one rx_valid_o, rx_data_o = 0x0807060504030201, rx_parity_err_o=0, busy low after.
- PARITY "E": corrupt the parity bit of word 3 -> rx_valid_o with rx_parity_err_o=1, data still correct.
- Stop bit of word 5 driven low -> rx_frame_err_o single pulse, no rx_valid_o, rx_data_o unchanged. Line high then a clean frame -> accepted.
- 4 words sent then line idle > 16*86 cycles -> rx_timeout_o pulse. Next full frame -> word 0 is its first byte.
- 20-cycle low glitch on idle line -> no pulses, stays IDLE. With UART_RX_MAJORITY_EN, a 1-cycle glitch at mid-bit of data bit 2 -> data unaffected.
- Assert rst_i during word 2 data bits -> all outputs 0 next cycle. A following frame is received correctly.
